// File: rtl/emu_cycle_sequencer_pkg.sv
// Shared definitions for the emulation cycle sequencer:
// FSM state encoding, default parameters and widths.
package emu_cycle_sequencer_pkg;

  localparam int DEF_NUM_STIM = 1;
  localparam int DEF_NUM_OUT  = 2;
  localparam int DEF_ADDR_W   = 3;
  localparam int DEF_CLK_HI   = 2;
  localparam int DEF_CLK_LO   = 2;

  localparam int IDX_W = 3;
  localparam int TMR_W = 8;
  localparam int CYC_W = 16;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_WSTIM = 4'd1,
    S_WSET  = 4'd2,
    S_LOAD  = 4'd3,
    S_CLKH  = 4'd4,
    S_CLKL  = 4'd5,
    S_GET   = 4'd6,
    S_RADDR = 4'd7,
    S_RCAP  = 4'd8,
    S_ROUT  = 4'd9,
    S_DONE  = 4'd10
  } state_t;

  // Timer reload value for a phase lasting n clk cycles
  function automatic logic [TMR_W-1:0] phase_load(input int n);
    return TMR_W'(n - 1);
  endfunction

endpackage

// File: rtl/emu_phase_timer.sv
// Loadable down-counter timing the clk_dut high/low phases.
// zero is high when the current phase is in its last cycle.
module emu_phase_timer
  import emu_cycle_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [TMR_W-1:0] i_value,
  input  logic             i_en,
  output logic             o_zero
);

  logic [TMR_W-1:0] r_cnt;

  // Reload on phase entry, count down while the phase runs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/emu_cycle_sequencer.sv
// Host-side sequencer: per DUT cycle writes stimulus bytes,
// loads, clocks the DUT once, gets and streams output bytes.
module emu_cycle_sequencer
  import emu_cycle_sequencer_pkg::*;
#(
  parameter int NUM_STIM = DEF_NUM_STIM,
  parameter int NUM_OUT  = DEF_NUM_OUT,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int CLK_HI   = DEF_CLK_HI,
  parameter int CLK_LO   = DEF_CLK_LO
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       n_cycles,
  output logic              busy,
  output logic              done,
  input  logic [7:0]        stim_data,
  input  logic              stim_valid,
  output logic              stim_ready,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        Din_emu,
  output logic [ADDR_W-1:0] Addr_emu,
  output logic              load_emu,
  output logic              get_emu,
  output logic              clk_dut,
  input  logic [7:0]        Dout_emu
);

  state_t r_state;
  state_t w_next;

  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic [CYC_W-1:0]  r_cyc;
  logic [CYC_W-1:0]  r_ncyc;

  logic              r_busy;
  logic              r_done;
  logic              r_stim_ready;
  logic              r_out_valid;
  logic [7:0]        r_out_data;
  logic [7:0]        r_din;
  logic [ADDR_W-1:0] r_addr;
  logic              r_load;
  logic              r_get;
  logic              r_clk_dut;

  logic              w_start;
  logic              w_stim_hs;
  logic              w_out_hs;
  logic              w_last_stim;
  logic              w_last_out;
  logic              w_last_cyc;
  logic              w_tload;
  logic [TMR_W-1:0]  w_tval;
  logic              w_ten;
  logic              w_tzero;

  assign w_start     = (r_state == S_IDLE) && start;
  assign w_stim_hs   = r_stim_ready && stim_valid;
  assign w_out_hs    = r_out_valid && out_ready;
  assign w_last_stim = (r_idx == IDX_W'(NUM_STIM - 1));
  assign w_last_out  = (r_idx == IDX_W'(NUM_OUT - 1));
  assign w_last_cyc  = ((r_cyc + 1'b1) == r_ncyc);

  // Next-state decode
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (n_cycles == '0) ? S_DONE : S_WSTIM;
        end
      end
      S_WSTIM: begin
        if (w_stim_hs && w_last_stim) w_next = S_WSET;
      end
      S_WSET:  w_next = S_LOAD;
      S_LOAD:  w_next = S_CLKH;
      S_CLKH: begin
        if (w_tzero) w_next = S_CLKL;
      end
      S_CLKL: begin
        if (w_tzero) w_next = S_GET;
      end
      S_GET:   w_next = S_RADDR;
      S_RADDR: w_next = S_RCAP;
      S_RCAP:  w_next = S_ROUT;
      S_ROUT: begin
        if (w_out_hs) begin
          if (!w_last_out)     w_next = S_RADDR;
          else if (w_last_cyc) w_next = S_DONE;
          else                 w_next = S_WSTIM;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Byte index shared by stimulus write and output readback
  always_comb begin
    w_idx_nxt = r_idx;
    if (w_start) begin
      w_idx_nxt = '0;
    end else if (w_stim_hs) begin
      w_idx_nxt = w_last_stim ? '0 : r_idx + 1'b1;
    end else if (w_out_hs) begin
      w_idx_nxt = w_last_out ? '0 : r_idx + 1'b1;
    end
  end

  // Phase timer control: reload when entering CLKH or CLKL
  always_comb begin
    w_tload = 1'b0;
    w_tval  = phase_load(CLK_LO);
    w_ten   = (r_state == S_CLKH) || (r_state == S_CLKL);
    if ((w_next == S_CLKH) && (r_state != S_CLKH)) begin
      w_tload = 1'b1;
      w_tval  = phase_load(CLK_HI);
    end else if ((w_next == S_CLKL) && (r_state != S_CLKL)) begin
      w_tload = 1'b1;
    end
  end

  emu_phase_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_tload),
    .i_value (w_tval),
    .i_en    (w_ten),
    .o_zero  (w_tzero)
  );

  // State register and Moore strobes registered from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_stim_ready <= 1'b0;
      r_out_valid  <= 1'b0;
      r_load       <= 1'b0;
      r_get        <= 1'b0;
      r_clk_dut    <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_busy       <= (w_next != S_IDLE) && (w_next != S_DONE);
      r_done       <= (w_next == S_DONE);
      r_stim_ready <= (w_next == S_WSTIM);
      r_out_valid  <= (w_next == S_ROUT);
      r_load       <= (w_next == S_LOAD);
      r_get        <= (w_next == S_GET);
      r_clk_dut    <= (w_next == S_CLKH);
    end
  end

  // Counters, wrapper address/data and output byte capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx      <= '0;
      r_cyc      <= '0;
      r_ncyc     <= '0;
      r_din      <= '0;
      r_addr     <= '0;
      r_out_data <= '0;
    end else begin
      r_idx <= w_idx_nxt;
      if (w_start) begin
        r_ncyc <= n_cycles;
        r_cyc  <= '0;
      end else if (w_out_hs && w_last_out) begin
        r_cyc <= r_cyc + 1'b1;
      end
      if (w_stim_hs) begin
        r_din  <= stim_data;
        r_addr <= ADDR_W'(r_idx);
      end else if (w_next == S_RADDR) begin
        r_addr <= ADDR_W'(w_idx_nxt);
      end
      if (r_state == S_RCAP) begin
        r_out_data <= Dout_emu;
      end
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign stim_ready = r_stim_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign Din_emu    = r_din;
  assign Addr_emu   = r_addr;
  assign load_emu   = r_load;
  assign get_emu    = r_get;
  assign clk_dut    = r_clk_dut;

endmodule

// File: tb/tb_emu_cycle_sequencer.sv
// Bench for emu_cycle_sequencer with a registered wrapper model:
// out byte0 = stim ^ 0x17, out byte1 = stim + 0x2F.
module tb_emu_cycle_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] n_cycles = '0;
  logic        busy, done;
  logic [7:0]  stim_data = '0;
  logic        stim_valid = 1'b1;
  logic        stim_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  Din_emu;
  logic [2:0]  Addr_emu;
  logic        load_emu, get_emu, clk_dut;
  logic [7:0]  Dout_emu = '0;

  emu_cycle_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .n_cycles   (n_cycles),
    .busy       (busy),
    .done       (done),
    .stim_data  (stim_data),
    .stim_valid (stim_valid),
    .stim_ready (stim_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Din_emu    (Din_emu),
    .Addr_emu   (Addr_emu),
    .load_emu   (load_emu),
    .get_emu    (get_emu),
    .clk_dut    (clk_dut),
    .Dout_emu   (Dout_emu)
  );

  always #5 clk = ~clk;

  // Wrapper model and event counters
  logic [7:0] stim_reg [8];
  logic [7:0] dut_in = '0, o0 = '0, o1 = '0, l0 = '0, l1 = '0;
  logic       clk_q = 1'b0;
  logic       overlap = 1'b0;
  int n_rise = 0, n_hi = 0, n_load = 0, n_get = 0;
  int n_done = 0, n_shs = 0;
  logic [7:0] outq [$];

  always @(posedge clk) begin
    if (!load_emu && !get_emu) stim_reg[Addr_emu] <= Din_emu;
    if (load_emu) dut_in <= stim_reg[0];
    clk_q <= clk_dut;
    if (clk_dut && !clk_q) begin
      o0 <= dut_in ^ 8'h17;
      o1 <= dut_in + 8'h2F;
      n_rise <= n_rise + 1;
    end
    if (clk_dut) n_hi <= n_hi + 1;
    if (load_emu) n_load <= n_load + 1;
    if (get_emu) begin
      l0 <= o0;
      l1 <= o1;
      n_get <= n_get + 1;
    end
    if (load_emu && get_emu) overlap <= 1'b1;
    if (done) n_done <= n_done + 1;
    if (stim_valid && stim_ready) n_shs <= n_shs + 1;
    if (out_valid && out_ready) outq.push_back(out_data);
    Dout_emu <= Addr_emu[0] ? l1 : l0;
  end

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] n;
    logic [7:0]  base;
    bit          mid;
    int          lat;
    logic [7:0]  exp [6];
  } vec_t;

  vec_t vecs [4];

  task automatic run_vec(input vec_t v);
    int b_out, b_rise, b_hi, b_load, b_get, b_done, b_hs, k;
    bit seen;
    b_out  = outq.size();
    b_rise = n_rise;
    b_hi   = n_hi;
    b_load = n_load;
    b_get  = n_get;
    b_done = n_done;
    @(negedge clk);
    b_hs = n_shs;
    stim_data = v.base;
    n_cycles = v.n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cycles = 16'hFFFF;
    chk("busy_rise", busy, 1);
    k = 1;
    seen = 0;
    while (!seen && k < 2000) begin
      if (done) begin
        seen = 1;
      end else begin
        stim_data = v.base + 8'(n_shs - b_hs);
        if (v.mid && k == 5) begin
          start = 1'b1;
          n_cycles = 16'd7;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        k++;
      end
    end
    start = 1'b0;
    chk("done_seen", 32'(seen), 1);
    chk("latency", k - 1, v.lat);
    chk("busy_at_done", busy, 0);
    @(negedge clk);
    chk("done_pulse_1cyc", done, 0);
    chk("n_bytes", outq.size() - b_out, 2 * v.n);
    chk("n_rise", n_rise - b_rise, v.n);
    chk("n_hi", n_hi - b_hi, 2 * v.n);
    chk("n_load", n_load - b_load, v.n);
    chk("n_get", n_get - b_get, v.n);
    chk("n_done", n_done - b_done, 1);
    for (int i = 0; i < 2 * int'(v.n) && i < 6; i++) begin
      if (b_out + i < outq.size())
        chk($sformatf("out_byte%0d", i), outq[b_out + i], v.exp[i]);
      else
        chk($sformatf("out_byte%0d_missing", i), 0, 1);
    end
  endtask

  initial begin
    int k, bad, b_out, b_get, b_load, b_rise, b_done;
    logic [7:0] held;

    vecs[0].n = 16'd1; vecs[0].base = 8'h05; vecs[0].mid = 0;
    vecs[0].lat = 14;
    vecs[0].exp = '{8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[1].n = 16'd3; vecs[1].base = 8'h10; vecs[1].mid = 0;
    vecs[1].lat = 42;
    vecs[1].exp = '{8'h07, 8'h3F, 8'h06, 8'h40, 8'h05, 8'h41};
    vecs[2].n = 16'd2; vecs[2].base = 8'hF0; vecs[2].mid = 0;
    vecs[2].lat = 28;
    vecs[2].exp = '{8'hE7, 8'h1F, 8'hE6, 8'h20, 8'h00, 8'h00};
    vecs[3].n = 16'd1; vecs[3].base = 8'h05; vecs[3].mid = 1;
    vecs[3].lat = 14;
    vecs[3].exp = '{8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00};

    repeat (3) @(negedge clk);
    chk("rst_strobes",
        {busy, done, stim_ready, out_valid, load_emu, get_emu, clk_dut}, 0);
    chk("rst_data", {out_data, Din_emu, Addr_emu}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // n_cycles = 0: done in the cycle after start, no wrapper activity
    b_load = n_load; b_get = n_get; b_rise = n_rise;
    n_cycles = 16'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    @(negedge clk);
    chk("zero_done_low", done, 0);
    chk("zero_activity",
        (n_load - b_load) + (n_get - b_get) + (n_rise - b_rise), 0);

    // Output stall on byte 1
    b_out = outq.size();
    stim_data = 8'h05;
    n_cycles = 16'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (outq.size() - b_out < 1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    out_ready = 1'b0;
    k = 0;
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("stall_valid", out_valid, 1);
    held = out_data;
    chk("stall_byte1", held, 8'h34);
    b_get = n_get;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!out_valid || out_data !== held || clk_dut) bad++;
    end
    chk("stall_hold", bad, 0);
    chk("stall_no_get", n_get - b_get, 0);
    out_ready = 1'b1;
    k = 0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("stall_done", done, 1);
    chk("stall_nbytes", outq.size() - b_out, 2);
    if (outq.size() - b_out == 2) begin
      chk("stall_out0", outq[b_out], 8'h12);
      chk("stall_out1", outq[b_out + 1], 8'h34);
    end
    @(negedge clk);

    // Reset asserted during CLKH
    stim_data = 8'h77;
    n_cycles = 16'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!clk_dut && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("mid_clkh_reached", clk_dut, 1);
    b_done = n_done;
    reset = 1'b1;
    #1;
    chk("mid_rst_clk_dut", clk_dut, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_strobes",
        {done, stim_ready, out_valid, load_emu, get_emu}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_no_done", n_done - b_done, 0);
    run_vec(vecs[0]);

    chk("load_get_overlap", overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
